// File: rtl/multi_byte_add_ctrl_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | multi_byte_add_ctrl_pkg                                          |
// | Shared state encoding and slice width for the serial adder.      |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package multi_byte_add_ctrl_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/multi_byte_add_ctrl_slice.sv
`default_nettype none
// +------------------------------------------------------------------+
// | multi_byte_add_ctrl_slice                                        |
// | Combinational 8-bit ripple-carry adder slice.                    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module multi_byte_add_ctrl_slice
  import multi_byte_add_ctrl_pkg::*;
(
  input  logic [BYTE_W-1:0] x,
  input  logic [BYTE_W-1:0] y,
  input  logic              cin,
  output logic [BYTE_W-1:0] s,
  output logic              cout
);

  logic ripple;

  always_comb begin
    ripple = cin;
    s      = '0;
    for (int i = 0; i < BYTE_W; i++) begin
      s[i]   = x[i] ^ y[i] ^ ripple;
      ripple = (x[i] & y[i]) | (ripple & (x[i] ^ y[i]));
    end
    cout = ripple;
  end

endmodule
`default_nettype wire

// File: rtl/multi_byte_add_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | multi_byte_add_ctrl                                              |
// | Multi-byte adder sharing one 8-bit slice, one byte per cycle.    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module multi_byte_add_ctrl
  import multi_byte_add_ctrl_pkg::*;
#(
  parameter int NBYTES = 4
)
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [BYTE_W*NBYTES-1:0] x,
  input  logic [BYTE_W*NBYTES-1:0] y,
  input  logic                     cin,
  output logic                     ready,
  output logic                     busy,
  output logic                     done,
  output logic [BYTE_W*NBYTES-1:0] s,
  output logic                     cout
);

  localparam int W     = BYTE_W * NBYTES;
  localparam int IDX_W = $clog2(NBYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] byte_idx_q, byte_idx_d;
  logic             carry_q, carry_d;
  logic [W-1:0]     x_q, x_d;
  logic [W-1:0]     y_q, y_d;
  logic [W-1:0]     s_q, s_d;
  logic             cout_q, cout_d;

  logic [BYTE_W-1:0] op_x;
  logic [BYTE_W-1:0] op_y;
  logic [BYTE_W-1:0] slice_s;
  logic              slice_cout;

  // Operand byte mux feeding the single shared slice
  always_comb begin
    op_x = '0;
    op_y = '0;
    for (int i = 0; i < NBYTES; i++) begin
      if (byte_idx_q == IDX_W'(i)) begin
        op_x = x_q[i*BYTE_W +: BYTE_W];
        op_y = y_q[i*BYTE_W +: BYTE_W];
      end
    end
  end

  multi_byte_add_ctrl_slice u_slice (
    .x    (op_x),
    .y    (op_y),
    .cin  (carry_q),
    .s    (slice_s),
    .cout (slice_cout)
  );

  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    carry_d    = carry_q;
    x_d        = x_q;
    y_d        = y_q;
    s_d        = s_q;
    cout_d     = cout_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_RUN;
          x_d        = x;
          y_d        = y;
          carry_d    = cin;
          byte_idx_d = '0;
        end
      end
      ST_RUN: begin
        for (int i = 0; i < NBYTES; i++) begin
          if (byte_idx_q == IDX_W'(i)) begin
            s_d[i*BYTE_W +: BYTE_W] = slice_s;
          end
        end
        carry_d = slice_cout;
        // Index parks on the last byte rather than wrapping
        if (byte_idx_q == LAST_IDX) begin
          state_d = ST_DONE;
          cout_d  = slice_cout;
        end else begin
          byte_idx_d = byte_idx_q + IDX_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      byte_idx_q <= '0;
      carry_q    <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      s_q        <= '0;
      cout_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      carry_q    <= carry_d;
      x_q        <= x_d;
      y_q        <= y_d;
      s_q        <= s_d;
      cout_q     <= cout_d;
    end
  end

  assign ready = (state_q == ST_IDLE);
  assign busy  = (state_q == ST_RUN) || (state_q == ST_DONE);
  assign done  = (state_q == ST_DONE);
  assign s     = s_q;
  assign cout  = cout_q;

endmodule
`default_nettype wire

// File: tb/tb_multi_byte_add_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_multi_byte_add_ctrl                                           |
// | Scoreboard bench: timing/arithmetic model vs. serial adder.      |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_multi_byte_add_ctrl;

  localparam int NBYTES = 4;
  localparam int W      = 8 * NBYTES;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         cin;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] s;
  logic         cout;

  always #5 clk = ~clk;

  multi_byte_add_ctrl #(.NBYTES(NBYTES)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .x     (x),
    .y     (y),
    .cin   (cin),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .s     (s),
    .cout  (cout)
  );

  typedef struct {
    int unsigned  edge_no;
    logic [W-1:0] sum;
    logic         carry;
  } exp_t;

  exp_t        sb_q[$];
  int          checks   = 0;
  int          failures = 0;
  int unsigned edge_cnt = 0;
  int unsigned next_ok  = 0;
  logic        model_on = 1'b0;
  logic        pend_v   = 1'b0;
  int unsigned pend_edge;
  logic [W-1:0] pend_s;
  logic         pend_cout;
  logic [W-1:0] hold_s    = '0;
  logic         hold_cout = 1'b0;

  task automatic chk(input string name, input logic [W:0] act, input logic [W:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at edge %0d: actual=%h expected=%h", name, edge_cnt, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] r;
    for (int i = 0; i < NBYTES; i++) r[i*8 +: 8] = 8'($urandom);
    return r;
  endfunction

  // Reference model: an accepted op yields x+y+cin exactly NBYTES edges later;
  // the block can take a new op NBYTES+2 edges after the previous accept.
  always @(posedge clk) begin
    logic [W:0] sum;
    exp_t       e;
    edge_cnt++;
    if (rst) begin
      model_on  = 1'b1;
      sb_q.delete();
      pend_v    = 1'b0;
      hold_s    = '0;
      hold_cout = 1'b0;
      next_ok   = edge_cnt + 1;
    end else if (model_on) begin
      if (pend_v && edge_cnt == pend_edge) begin
        hold_s    = pend_s;
        hold_cout = pend_cout;
        pend_v    = 1'b0;
      end
      if (start && edge_cnt >= next_ok) begin
        sum       = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, cin};
        e.edge_no = edge_cnt + NBYTES;
        e.sum     = sum[W-1:0];
        e.carry   = sum[W];
        sb_q.push_back(e);
        pend_v    = 1'b1;
        pend_edge = e.edge_no;
        pend_s    = e.sum;
        pend_cout = e.carry;
        next_ok   = edge_cnt + NBYTES + 2;
      end
    end
  end

  // Monitor: compares handshake outputs every cycle and results on done
  always @(negedge clk) begin
    logic ready_exp;
    logic done_exp;
    exp_t e;
    if (model_on) begin
      ready_exp = (edge_cnt + 1 >= next_ok);
      done_exp  = (sb_q.size() > 0) && (sb_q[0].edge_no == edge_cnt);
      chk("ready", {{W{1'b0}}, ready}, {{W{1'b0}}, ready_exp});
      chk("busy",  {{W{1'b0}}, busy},  {{W{1'b0}}, !ready_exp});
      chk("done",  {{W{1'b0}}, done},  {{W{1'b0}}, done_exp});
      if (done && sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("done_s",    {1'b0, s},             {1'b0, e.sum});
        chk("done_cout", {{W{1'b0}}, cout},     {{W{1'b0}}, e.carry});
      end else if (sb_q.size() > 0 && sb_q[0].edge_no < edge_cnt) begin
        void'(sb_q.pop_front());
      end
      if (ready_exp) begin
        chk("idle_s",    {1'b0, s},         {1'b0, hold_s});
        chk("idle_cout", {{W{1'b0}}, cout}, {{W{1'b0}}, hold_cout});
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      checks++;
      failures++;
      $display("FAIL wait_ready: actual=busy expected=ready within 100 cycles");
    end
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    wait_ready();
    x     = a;
    y     = b;
    cin   = c;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    x     = rand_word();
    y     = rand_word();
    cin   = 1'(~c);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    x     = '0;
    y     = '0;
    cin   = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_op(32'h0000_0001, 32'h0000_0003, 1'b0);
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    run_op(32'h0000_00FF, 32'h0000_0000, 1'b1);

    // start held high while x keeps changing after the accept
    wait_ready();
    x = 32'h1234_5678; y = 32'h1111_1111; cin = 1'b0; start = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      x = rand_word();
    end
    @(negedge clk);
    start = 1'b0;

    // reset landing on the edge that would process byte 2
    wait_ready();
    x = rand_word(); y = rand_word(); cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    run_op(32'h0000_0001, 32'h0000_0003, 1'b0);

    // back-to-back with start tied high
    wait_ready();
    start = 1'b1;
    for (int i = 0; i < 60; i++) begin
      x   = rand_word();
      y   = rand_word();
      cin = 1'($urandom);
      @(negedge clk);
    end
    start = 1'b0;

    // random start traffic with sparse resets
    for (int i = 0; i < 300; i++) begin
      start = 1'($urandom_range(0, 1));
      rst   = ($urandom_range(0, 59) == 0);
      x     = (i % 7 == 0) ? '1 : rand_word();
      y     = rand_word();
      cin   = 1'($urandom);
      @(negedge clk);
    end
    rst   = 1'b0;
    start = 1'b0;
    repeat (NBYTES + 4) @(negedge clk);

    chk("drain", {{W{1'b0}}, (sb_q.size() == 0)}, {{W{1'b0}}, 1'b1});
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
